// File: rtl/matrix_ls_sequencer.sv
// Matrix load/store row sequencer: walks ROWS scratchpad row addresses (base + row*stride, mod 2^11).
// Optional mhit stall watchdog enabled by defining MLS_SEQ_TIMEOUT_EN.
module matrix_ls_sequencer #(
    parameter int ROWS    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [1:0]              ls_in,
    input  logic [4:0]              rd_in,
    input  logic [31:0]             rs_in,
    input  logic [31:0]             stride_in,
    input  logic [10:0]             imm_in,
    input  logic                    mhit,
    output logic                    ready,
    output logic                    sp_req,
    output logic [1:0]              sp_ls,
    output logic [10:0]             sp_addr,
    output logic [$clog2(ROWS)-1:0] sp_row,
    output logic [4:0]              rd_out,
    output logic                    done,
    output logic                    error
);

    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [10:0]        addr_reg;
    logic [10:0]        stride_reg;
    logic [1:0]         ls_reg;
    logic [4:0]         rd_reg;
    logic               ready_reg;
    logic               sp_req_reg;
    logic               done_reg;
    logic               error_reg;
    logic               legal_op;

    // Only the low 11 bits of the address operands take part in the arithmetic.
    logic unused_hi_bits;
    assign unused_hi_bits = &{1'b0, rs_in[31:11], stride_in[31:11]};

    assign legal_op = (ls_in == 2'b01) || (ls_in == 2'b10);

`ifdef MLS_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_cnt_reg;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            addr_reg   <= '0;
            stride_reg <= '0;
            ls_reg     <= '0;
            rd_reg     <= '0;
            ready_reg  <= 1'b1;
            sp_req_reg <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
`ifdef MLS_SEQ_TIMEOUT_EN
            stall_cnt_reg <= '0;
`endif
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (legal_op) begin
                            state_reg  <= ACCESS;
                            ls_reg     <= ls_in;
                            rd_reg     <= rd_in;
                            stride_reg <= stride_in[10:0];
                            addr_reg   <= rs_in[10:0] + imm_in;
                            row_reg    <= '0;
                            ready_reg  <= 1'b0;
                            sp_req_reg <= 1'b1;
`ifdef MLS_SEQ_TIMEOUT_EN
                            stall_cnt_reg <= '0;
`endif
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mhit) begin
`ifdef MLS_SEQ_TIMEOUT_EN
                        stall_cnt_reg <= '0;
`endif
                        if (row_reg == LAST_ROW) begin
                            state_reg  <= DONE;
                            sp_req_reg <= 1'b0;
                            done_reg   <= 1'b1;
                        end else begin
                            // Running address avoids a row*stride multiplier.
                            row_reg  <= row_reg + 1'b1;
                            addr_reg <= addr_reg + stride_reg;
                        end
                    end
`ifdef MLS_SEQ_TIMEOUT_EN
                    else if (stall_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg  <= DONE;
                        sp_req_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        error_reg  <= 1'b1;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= IDLE;
                    ready_reg  <= 1'b1;
                    sp_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_reg;
    assign sp_req  = sp_req_reg;
    assign sp_ls   = ls_reg;
    assign sp_addr = addr_reg;
    assign sp_row  = row_reg;
    assign rd_out  = rd_reg;
    assign done    = done_reg;
    assign error   = error_reg;

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Directed self-checking bench for matrix_ls_sequencer (ROWS=4, TIMEOUT=8).
module tb_matrix_ls_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  ls_in;
    logic [4:0]  rd_in;
    logic [31:0] rs_in;
    logic [31:0] stride_in;
    logic [10:0] imm_in;
    logic        mhit;
    logic        ready;
    logic        sp_req;
    logic [1:0]  sp_ls;
    logic [10:0] sp_addr;
    logic [1:0]  sp_row;
    logic [4:0]  rd_out;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_ls_sequencer #(.ROWS(4), .TIMEOUT(8)) dut (
        .CLK(clk), .RST(rst), .start(start), .ls_in(ls_in), .rd_in(rd_in),
        .rs_in(rs_in), .stride_in(stride_in), .imm_in(imm_in), .mhit(mhit),
        .ready(ready), .sp_req(sp_req), .sp_ls(sp_ls), .sp_addr(sp_addr),
        .sp_row(sp_row), .rd_out(rd_out), .done(done), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and advances one edge; on return the bench sits in cycle 1.
    task automatic issue(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] rs,
                         input logic [31:0] stride, input logic [10:0] imm);
        ls_in = ls; rd_in = rd; rs_in = rs; stride_in = stride; imm_in = imm;
        start = 1'b1;
        step();
        start = 1'b0;
        $display("op ls=%b rd=%0d rs=%0d imm=%0d stride=%0d", ls, rd, rs[10:0], imm, stride[10:0]);
    endtask

    // Walks all four rows with 'stall' mhit-low cycles before each hit, then checks completion.
    task automatic run_rows(input int stall, input logic [10:0] a0, input logic [10:0] a1,
                            input logic [10:0] a2, input logic [10:0] a3,
                            input logic [4:0] rd, input logic [1:0] ls);
        logic [10:0] exp_a [4];
        exp_a = '{a0, a1, a2, a3};
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j <= stall; j++) begin
                mhit = (j == stall);
                check("row_sp_req", 32'(sp_req), 32'd1);
                check("row_sp_addr", 32'(sp_addr), 32'(exp_a[r]));
                check("row_sp_row", 32'(sp_row), 32'(r));
                check("row_done", 32'(done), 32'd0);
                check("row_ready", 32'(ready), 32'd0);
                step();
            end
        end
        mhit = 1'b0;
        check("end_done", 32'(done), 32'd1);
        check("end_error", 32'(error), 32'd0);
        check("end_sp_req", 32'(sp_req), 32'd0);
        check("end_sp_ls", 32'(sp_ls), 32'(ls));
        check("end_rd_out", 32'(rd_out), 32'(rd));
        step();
        check("post_done", 32'(done), 32'd0);
        check("post_ready", 32'(ready), 32'd1);
        check("post_error", 32'(error), 32'd0);
        $display("op complete rd=%0d", rd);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ls_in = 2'b00; rd_in = '0; rs_in = '0;
        stride_in = '0; imm_in = '0; mhit = 1'b0;
        step();
        step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_sp_req", 32'(sp_req), 32'd0);
        check("rst_sp_addr", 32'(sp_addr), 32'd0);
        check("rst_sp_row", 32'(sp_row), 32'd0);
        check("rst_sp_ls", 32'(sp_ls), 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        step();

        // LOAD, mhit held high: rows in cycles 1..4, done in 5.
        mhit = 1'b1;
        issue(2'b01, 5'd15, 32'd100, 32'd5, 11'd20);
        run_rows(0, 11'd120, 11'd125, 11'd130, 11'd135, 5'd15, 2'b01);

        // STORE with two stall cycles per row.
        issue(2'b10, 5'd4, 32'd25, 32'd3, 11'd30);
        run_rows(2, 11'd55, 11'd58, 11'd61, 11'd64, 5'd4, 2'b10);

        // Wrap mod 2^11, upper operand bits ignored (rs low=2040, stride low=4).
        issue(2'b01, 5'd3, 32'hABCD_07F8, 32'h1234_5804, 11'd0);
        run_rows(0, 11'd2040, 11'd2044, 11'd0, 11'd4, 5'd3, 2'b01);

        // Illegal ops: error pulse, nothing latched, stays idle.
        issue(2'b11, 5'd7, 32'd9, 32'd9, 11'd9);
        check("ill11_error", 32'(error), 32'd1);
        check("ill11_ready", 32'(ready), 32'd1);
        check("ill11_sp_req", 32'(sp_req), 32'd0);
        check("ill11_done", 32'(done), 32'd0);
        check("ill11_rd_out", 32'(rd_out), 32'd3);
        check("ill11_sp_ls", 32'(sp_ls), 32'd1);
        step();
        check("ill11_error_clr", 32'(error), 32'd0);
        check("ill11_sp_req2", 32'(sp_req), 32'd0);
        issue(2'b00, 5'd8, 32'd9, 32'd9, 11'd9);
        check("ill00_error", 32'(error), 32'd1);
        check("ill00_ready", 32'(ready), 32'd1);
        check("ill00_sp_addr", 32'(sp_addr), 32'd4);
        step();
        check("ill00_error_clr", 32'(error), 32'd0);

        // Start while busy is ignored.
        mhit = 1'b0;
        issue(2'b01, 5'd9, 32'd0, 32'd16, 11'd50);
        start = 1'b1; ls_in = 2'b10; rd_in = 5'd22; rs_in = 32'd700;
        step(); step(); step();
        start = 1'b0;
        check("busy_rd_out", 32'(rd_out), 32'd9);
        check("busy_sp_ls", 32'(sp_ls), 32'd1);
        check("busy_sp_addr", 32'(sp_addr), 32'd50);
        check("busy_sp_row", 32'(sp_row), 32'd0);
        check("busy_error", 32'(error), 32'd0);
        run_rows(0, 11'd50, 11'd66, 11'd82, 11'd98, 5'd9, 2'b01);
        step();
        check("busy_no_requeue", 32'(ready), 32'd1);

        // Reset during row 2 abandons the operation.
        mhit = 1'b1;
        issue(2'b01, 5'd5, 32'd0, 32'd1, 11'd10);
        step(); step();
        check("mid_row", 32'(sp_row), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mhit = 1'b0;
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_sp_req", 32'(sp_req), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        check("mid_sp_row", 32'(sp_row), 32'd0);
        check("mid_rd_out", 32'(rd_out), 32'd0);
        step();
        check("mid_done2", 32'(done), 32'd0);
        check("mid_sp_req2", 32'(sp_req), 32'd0);
        $display("op aborted by reset");
        issue(2'b01, 5'd15, 32'd100, 32'd5, 11'd20);
        run_rows(0, 11'd120, 11'd125, 11'd130, 11'd135, 5'd15, 2'b01);

`ifdef MLS_SEQ_TIMEOUT_EN
        // Watchdog: done and error together 8 cycles after entering ACCESS.
        mhit = 1'b0;
        issue(2'b10, 5'd2, 32'd0, 32'd1, 11'd0);
        for (int k = 1; k <= 8; k++) begin
            check("to_sp_req", 32'(sp_req), 32'd1);
            check("to_done_early", 32'(done), 32'd0);
            check("to_error_early", 32'(error), 32'd0);
            step();
        end
        check("to_done", 32'(done), 32'd1);
        check("to_error", 32'(error), 32'd1);
        step();
        check("to_ready", 32'(ready), 32'd1);
        check("to_error_clr", 32'(error), 32'd0);
        $display("op timed out");
`else
        // Without the watchdog the request waits indefinitely.
        begin
            int held;
            held = 0;
            mhit = 1'b0;
            issue(2'b10, 5'd2, 32'd0, 32'd1, 11'd0);
            for (int k = 0; k < 100; k++) begin
                if (sp_req === 1'b1 && done === 1'b0 && error === 1'b0) held++;
                step();
            end
            check("wait_req_held", 32'(held), 32'd100);
            run_rows(0, 11'd0, 11'd1, 11'd2, 11'd3, 5'd2, 2'b10);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_ls_sequencer.md
MATRIX_LS_SEQUENCER -- requirements
Module: matrix_ls_sequencer

Interface
REQ-001 Parameter: ROWS, 4, number of matrix rows transferred per operation (power of two, 2..16).
REQ-002 Parameter: TIMEOUT, 64, mhit-wait limit in cycles (used only when MLS_SEQ_TIMEOUT_EN is defined).
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  operation request, sampled only when ready=1.
REQ-006 Port: ls_in  input  2  operation select: 2'b01 LOAD, 2'b10 STORE, other values illegal.
REQ-007 Port: rd_in  input  5  matrix register index.
REQ-008 Port: rs_in  input  32 (word_t)  base address register value.
REQ-009 Port: stride_in  input  32 (word_t)  row-to-row address stride.
REQ-010 Port: imm_in  input  11  address offset.
REQ-011 Port: mhit  input  1  scratchpad acknowledges current row access.
REQ-012 Port: ready  output  1  sequencer idle and accepting start.
REQ-013 Port: sp_req  output  1  scratchpad row access request.
REQ-014 Port: sp_ls  output  2  latched operation type for the scratchpad.
REQ-015 Port: sp_addr  output  11  current row address.
REQ-016 Port: sp_row  output  $clog2(ROWS)  current row index.
REQ-017 Port: rd_out  output  5  latched matrix register index.
REQ-018 Port: done  output  1  one-cycle completion pulse.
REQ-019 Port: error  output  1  one-cycle fault pulse.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE; ready=1 only in IDLE.
REQ-021 In IDLE with start=1 and ls_in in {01,10}, the block SHALL latch ls_in, rd_in, stride_in[10:0] and base=(rs_in[10:0]+imm_in) mod 2^11, set row=0 and enter ACCESS next cycle.
REQ-022 In IDLE with start=1 and ls_in in {00,11}, the block SHALL pulse error for one cycle the next cycle, latch nothing and remain in IDLE; done SHALL stay 0.
REQ-023 In ACCESS, sp_req SHALL be 1; sp_addr SHALL equal (base + row*stride) mod 2^11; sp_row SHALL equal row.
REQ-024 A row transfer completes in a cycle where sp_req=1 and mhit=1; sp_req, sp_addr and sp_row SHALL hold steady until that cycle.
REQ-025 On completion with row<ROWS-1, row SHALL increment and the FSM SHALL stay in ACCESS; on completion with row=ROWS-1 it SHALL enter DONE.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 With mhit held at 1, start accepted in cycle 0 SHALL give rows in cycles 1..ROWS, done in cycle ROWS+1, ready again in cycle ROWS+2.
REQ-028 start SHALL be ignored while ready=0; no queuing.
REQ-029 mhit SHALL be ignored outside ACCESS.
REQ-030 sp_ls and rd_out SHALL hold latched values from acceptance until the next accepted start.
REQ-031 Address arithmetic SHALL wrap modulo 2^11; stride bits above [10:0] SHALL be ignored.

Reset
REQ-032 RST=1 at any clock edge SHALL force IDLE, row=0 and all outputs to 0 except ready=1, including mid-ACCESS; an in-flight operation SHALL be abandoned without done or error.

Configuration
REQ-033 With MLS_SEQ_TIMEOUT_EN defined, a counter SHALL count consecutive ACCESS cycles with mhit=0, clearing on each completion; on reaching TIMEOUT the FSM SHALL enter DONE and pulse error together with done.
REQ-034 Without MLS_SEQ_TIMEOUT_EN, ACCESS SHALL wait for mhit indefinitely and error SHALL arise only from REQ-022.

Verification
REQ-035 LOAD: ls_in=01, rd_in=15, rs_in=100, imm_in=20, stride_in=5, mhit=1 -> sp_addr 120,125,130,135 in cycles 1..4, sp_ls=01, rd_out=15, done in cycle 5.
REQ-036 STORE with stalls: ls_in=10, rs_in=25, imm_in=30, stride_in=3, mhit low 2 cycles per row -> sp_addr 55,58,61,64 each held 3 cycles, done once, error=0.
REQ-037 Wrap: rs_in=2040, imm_in=0, stride_in=4 -> sp_addr 2040,2044,0,4.
REQ-038 Illegal op: ls_in=11, start=1 -> error pulse 1 cycle, ready stays 1, sp_req never asserted; repeat start while busy -> ignored.
REQ-039 Reset mid-op: RST=1 during row 2 -> next cycle ready=1, sp_req=0, done=0; new LOAD then completes normally.
REQ-040 Timeout (MLS_SEQ_TIMEOUT_EN, TIMEOUT=8): mhit=0 throughout -> done and error pulse together 8 cycles after entering ACCESS; without macro, sp_req stays 1 for 100 cycles.
